// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scan controller.
// Glyphs are active-low cathode patterns, bit0 = segment a .. bit6 = segment g.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

    // One complete 4-digit display image: digits[0] is least significant.
    typedef struct packed {
        logic [3:0][3:0] digits;
        logic [3:0]      dp_en;
    } frame_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
// Every 4-bit value has a glyph, so there is no illegal input.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        unique case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed seven-segment scan controller with a one-deep pending buffer
// committed only at frame boundaries. Optional leading-zero blanking: SEG_LZ_SUPPRESS_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 12000,
    parameter int unsigned BLANK_CYCLES = 200
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       idx;
    frame_t           pend;
    frame_t           disp;
    logic             pend_full;

    logic             slot_wrap;
    logic             frame_end;
    logic             accept;
    phase_e           phase;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;
    logic [6:0]       glyph;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_end  = slot_wrap && (idx == 2'd3);
    assign load_ready = !pend_full;
    assign accept     = load_valid && load_ready;
    assign phase      = (slot_cnt < BLANK_END) ? BLANK : DRIVE;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Commit wins over accept at the boundary; ready is low then, so they never collide.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            disp      <= '0;
            pend_full <= 1'b0;
        end else if (frame_end && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_full <= 1'b1;
        end
    end

    // NOTE: the pending data is left without reset; pend_full qualifies it, so its
    // content after reset is never observed and the flops stay plain data registers.
    always_ff @(posedge sysclk) begin
        if (accept) begin
            pend.digits <= {digit3, digit2, digit1, digit0};
            pend.dp_en  <= dp_en;
        end
    end

    assign cur_digit = disp.digits[idx];

    seg_decoder u_decoder (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef SEG_LZ_SUPPRESS_EN
    logic lz_blank;

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd3:    lz_blank = (disp.digits[3] == 4'd0);
            2'd2:    lz_blank = (disp.digits[3] == 4'd0) && (disp.digits[2] == 4'd0);
            2'd1:    lz_blank = (disp.digits[3] == 4'd0) && (disp.digits[2] == 4'd0)
                                && (disp.digits[1] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end

    assign glyph = lz_blank ? SEG_BLANK : dec_seg;
`else
    assign glyph = dec_seg;
`endif

    // NOTE: every output of this block gets a default first, so no path through it
    // leaves a variable unassigned and no latch can be inferred.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (phase == DRIVE) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = glyph;
            dp_d  = ~disp.dp_en[idx];
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=8, BLANK_CYCLES=2): a cycle-indexed
// reference model checked every cycle, directed scenarios with literal glyphs, then random loads.
module tb_seg_scan_ctrl;

    localparam int S     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * S;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0, digit3 = '0;
    logic [3:0] dp_en = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 sysclk = ~sysclk;

    seg_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp_en      (dp_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent glyph table, active-low, bit0 = segment a.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: m_t counts clocks since reset; the display image changes only
    // at frame ends, and the outputs lag the scan position by one clock.
    int          m_t  = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_dpd = '0, m_pdp = '0;
    bit          m_pf = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    function automatic logic [11:0] expect_out(input int t);
        int         slot, i;
        logic [3:0] d, a;
        logic [6:0] g;
        slot = t % S;
        i    = (t / S) % 4;
        if (slot < B) return {4'hF, 7'h7F, 1'b1};
        d = 4'((m_disp >> (4 * i)) & 16'hF);
        g = glyph[d];
`ifdef SEG_LZ_SUPPRESS_EN
        if (i > 0 && (m_disp >> (4 * i)) == 16'd0) g = 7'h7F;
`endif
        a = ~(4'b0001 << i);
        return {a, g, ~m_dpd[i]};
    endfunction

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            m_disp <= '0;
            m_dpd  <= '0;
            m_pf   <= 1'b0;
            {e_an, e_seg, e_dp} <= {4'hF, 7'h7F, 1'b1};
        end else begin
            {e_an, e_seg, e_dp} <= expect_out(m_t);
            if ((m_t % S) == S - 1 && ((m_t / S) % 4) == 3 && m_pf) begin
                m_disp <= m_pend;
                m_dpd  <= m_pdp;
                m_pf   <= 1'b0;
            end else if (load_valid && !m_pf) begin
                m_pend <= {digit3, digit2, digit1, digit0};
                m_pdp  <= dp_en;
                m_pf   <= 1'b1;
            end
            m_t <= m_t + 1;
        end
    end

    initial forever begin
        @(negedge sysclk);
        check("scan {an,seg,dp,ready}", {3'b0, an, seg, dp, load_ready},
              {3'b0, e_an, e_seg, e_dp, !m_pf});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Waits for the start of the next DRIVE slot whose anode pattern is target.
    task automatic wait_an(input logic [3:0] target);
        int k = 0;
        while (an == target && k < 200) begin @(negedge sysclk); k++; end
        while (an != target && k < 200) begin @(negedge sysclk); k++; end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_an timeout: an=%b wanted %b", an, target);
        end
    endtask

    task automatic offer(input logic [15:0] v, input logic [3:0] dps);
        {digit3, digit2, digit1, digit0} = v;
        dp_en      = dps;
        load_valid = 1'b1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        check("ready_after_reset", 16'(load_ready), 16'd1);
        cycles(1);
        check("first_slot_blank_an", 16'(an), 16'hF);
        cycles(2);
        check("first_drive_an", 16'(an), 16'hE);
        check("first_drive_seg0", 16'(seg), 16'h40);
        wait_an(4'b1101);
`ifdef SEG_LZ_SUPPRESS_EN
        check("zero_digit1_suppressed", 16'(seg), 16'h7F);
`else
        check("zero_digit1_seg", 16'(seg), 16'h40);
`endif

        // Mid-frame load of 4,3,2,1 (d3..d0): held until the frame ends.
        offer(16'h4321, 4'b0000);
        cycles(1);
        load_valid = 1'b0;
        check("ready_drop_after_load", 16'(load_ready), 16'd0);
        wait_an(4'b1110);
        check("commit_digit0_1", 16'(seg), 16'h79);
        wait_an(4'b1101);
        check("commit_digit1_2", 16'(seg), 16'h24);
        wait_an(4'b0111);
        check("commit_digit3_4", 16'(seg), 16'h19);

        // Load A, then hold valid with B while pending is full.
        offer(16'h8765, 4'b0001);
        cycles(1);
        offer(16'hCBA9, 4'b1000);
        check("held_not_ready", 16'(load_ready), 16'd0);
        k = 0;
        while (load_ready !== 1'b1 && k < 200) begin cycles(1); k++; end
        if (k >= 200) begin total++; bad++; $display("FAIL ready_return timeout"); end
        cycles(1);
        load_valid = 1'b0;
        check("held_value_accepted", 16'(load_ready), 16'd0);
        wait_an(4'b1110);
        check("frame_a_digit0_5", 16'(seg), 16'h12);
        check("frame_a_dp0_on", 16'(dp), 16'd0);
        wait_an(4'b1110);
        check("frame_b_digit0_9", 16'(seg), 16'h10);
        check("frame_b_dp0_off", 16'(dp), 16'd1);
        wait_an(4'b0111);
        check("frame_b_digit3_c", 16'(seg), 16'h46);
        check("frame_b_dp3_on", 16'(dp), 16'd0);

        // Load exactly in the frame-boundary cycle: shown only from the next boundary.
        k = 0;
        while (!(load_ready === 1'b1 && (m_t % FRAME) == FRAME - 1) && k < 200) begin
            cycles(1);
            k++;
        end
        if (k >= 200) begin total++; bad++; $display("FAIL boundary_wait timeout"); end
        offer(16'h0007, 4'b0000);
        cycles(1);
        load_valid = 1'b0;
        check("boundary_load_pending", 16'(load_ready), 16'd0);
        wait_an(4'b1110);
        check("boundary_old_digit0_9", 16'(seg), 16'h10);
        wait_an(4'b1110);
        check("boundary_new_digit0_7", 16'(seg), 16'h78);
        wait_an(4'b0111);
`ifdef SEG_LZ_SUPPRESS_EN
        check("lz_digit3_blank", 16'(seg), 16'h7F);
`else
        check("digit3_zero", 16'(seg), 16'h40);
`endif

        // Reset mid-DRIVE with a value pending.
        offer(16'h1111, 4'b1111);
        cycles(1);
        load_valid = 1'b0;
        check("pending_before_reset", 16'(load_ready), 16'd0);
        k = 0;
        while (an == 4'hF && k < 100) begin cycles(1); k++; end
        #1 rst_n = 1'b0;
        #1;
        check("reset_blank_outputs", {4'b0, an, seg, dp}, {4'b0, 4'hF, 7'h7F, 1'b1});
        check("reset_ready", 16'(load_ready), 16'd1);
        cycles(2);
        rst_n = 1'b1;
        wait_an(4'b1110);
        check("post_reset_digit0_0", 16'(seg), 16'h40);
        check("post_reset_dp_off", 16'(dp), 16'd1);

        // Random loads, with one reset pulse in the middle.
        for (int i = 0; i < 900; i++) begin
            cycles(1);
            load_valid = ($urandom_range(0, 3) == 0);
            digit0 = 4'($urandom_range(0, 15));
            digit1 = 4'($urandom_range(0, 15));
            digit2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            digit3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dp_en  = 4'($urandom_range(0, 15));
            if (i == 450) rst_n = 1'b0;
            if (i == 452) rst_n = 1'b1;
        end
        load_valid = 1'b0;
        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
